// File: rtl/demux_lane_packer.sv
// demux_lane_packer: packs 2-bit demux lane symbols (lane B / lane C) into words,
// one accumulator + one holding register per lane, round-robin onto a single
// registered valid/ready output tagged with the source lane.
// Optional feature macro: DEMUX_PACK_FLUSH_EN (adds a flush input that pushes
// partial words out zero-padded).
module demux_lane_packer #(
    parameter int SYM_W         = 2,
    parameter int SYMS_PER_WORD = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef DEMUX_PACK_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic                           sym_valid,
    input  logic                           sym_sel,
    input  logic [SYM_W-1:0]               sym_b,
    input  logic [SYM_W-1:0]               sym_c,
    output logic                           sym_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SYM_W*SYMS_PER_WORD-1:0] out_data,
    output logic                           out_chan
);

    localparam int WORD_W = SYM_W * SYMS_PER_WORD;
    localparam int CNT_W  = $clog2(SYMS_PER_WORD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMS_PER_WORD - 1);

    logic [CNT_W-1:0]  cnt_q  [0:1];
    logic [CNT_W-1:0]  cnt_d  [0:1];
    logic [WORD_W-1:0] acc_q  [0:1];
    logic [WORD_W-1:0] acc_d  [0:1];
    logic [WORD_W-1:0] hold_q [0:1];
    logic [WORD_W-1:0] hold_d [0:1];
    logic [1:0]        hold_v_q, hold_v_d;
    logic              rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_chan_q, out_chan_d;

    logic              flush_w;
    logic [SYM_W-1:0]  sym_in;
    logic              last_sym;
    logic              accept;
    logic              out_load;
    logic              gnt_any;
    logic              gnt_lane;

`ifdef DEMUX_PACK_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Input lane select, stall decision and output-side grant selection
    always_comb begin
        sym_in    = sym_sel ? sym_c : sym_b;
        last_sym  = (cnt_q[sym_sel] == LAST);
        // Stall looks at the pre-edge hold flag, so a draining hold still costs one bubble
        sym_ready = !(last_sym && hold_v_q[sym_sel]) && !flush_w;
        accept    = sym_valid && sym_ready;
        out_load  = !out_valid_q || out_ready;
        gnt_any   = |hold_v_q;
        gnt_lane  = (&hold_v_q) ? rr_q : hold_v_q[1];
    end

    // Next state: grant first, then completion/flush so a same-edge refill keeps hold_v set
    always_comb begin
        int base;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        base        = int'(cnt_q[sym_sel]) * SYM_W;

        if (out_load) begin
            if (gnt_any) begin
                out_valid_d        = 1'b1;
                out_data_d         = hold_q[gnt_lane];
                out_chan_d         = gnt_lane;
                hold_v_d[gnt_lane] = 1'b0;
                if (&hold_v_q) rr_d = ~gnt_lane;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (accept) begin
            if (last_sym) begin
                hold_d[sym_sel]   = {sym_in, acc_q[sym_sel][WORD_W-SYM_W-1:0]};
                hold_v_d[sym_sel] = 1'b1;
                cnt_d[sym_sel]    = '0;
                acc_d[sym_sel]    = '0;
            end else begin
                acc_d[sym_sel][base +: SYM_W] = sym_in;
                cnt_d[sym_sel]                = cnt_q[sym_sel] + CNT_W'(1);
            end
        end

        // Upper symbols of a partial accumulator are already zero, giving the padding
        for (int l = 0; l < 2; l++) begin
            if (flush_w && (cnt_q[l] != '0) && !hold_v_q[l]) begin
                hold_d[l]   = acc_q[l];
                hold_v_d[l] = 1'b1;
                cnt_d[l]    = '0;
                acc_d[l]    = '0;
            end
        end
    end

    // State registers; everything clears on reset so partial and held words are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                cnt_q[l]  <= '0;
                acc_q[l]  <= '0;
                hold_q[l] <= '0;
            end
            hold_v_q    <= '0;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                cnt_q[l]  <= cnt_d[l];
                acc_q[l]  <= acc_d[l];
                hold_q[l] <= hold_d[l];
            end
            hold_v_q    <= hold_v_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_demux_lane_packer.sv
// Directed bench for demux_lane_packer: reset, single lane, interleave,
// back-pressure, arbitration and (with DEMUX_PACK_FLUSH_EN) flush.
module tb_demux_lane_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sym_valid = 1'b0;
    logic       sym_sel = 1'b0;
    logic [1:0] sym_b = '0;
    logic [1:0] sym_c = '0;
    logic       sym_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_chan;
`ifdef DEMUX_PACK_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] q[$];

    demux_lane_packer #(.SYM_W(2), .SYMS_PER_WORD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX_PACK_FLUSH_EN
        .flush     (flush),
`endif
        .sym_valid (sym_valid),
        .sym_sel   (sym_sel),
        .sym_b     (sym_b),
        .sym_c     (sym_c),
        .sym_ready (sym_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    // Record every output handshake as {chan, data}
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) q.push_back({out_chan, out_data});
    end

    task automatic send(input logic lane, input logic [1:0] v);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        sym_valid = 1'b1;
        sym_sel   = lane;
        if (lane) begin sym_c = v; sym_b = ~v; end
        else      begin sym_b = v; sym_c = ~v; end
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (sym_ready) begin @(posedge clk); ok = 1'b1; end
            else @(negedge clk);
        end
        #1 sym_valid = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: lane %0d symbol %0d never accepted", lane, v);
        end
    endtask

    task automatic send_word(input logic lane, input logic [1:0] s0, input logic [1:0] s1,
                             input logic [1:0] s2, input logic [1:0] s3);
        send(lane, s0); send(lane, s1); send(lane, s2); send(lane, s3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; out_ready = 1'b0; sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 1'b0 || sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL por_state: valid=%b data=%h chan=%b ready=%b, want 0 00 0 1",
                     out_valid, out_data, out_chan, sym_ready);
        end
        do_reset();
        send_word(1'b0, 2'd3, 2'd2, 2'd1, 2'd3);
        send(1'b1, 2'd1); send(1'b1, 2'd1);
        repeat (2) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_valid: got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h ready=%b, want 0 00 1",
                     out_valid, out_data, sym_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        q.delete();
        send(1'b1, 2'd2); send(1'b1, 2'd2); send(1'b1, 2'd2);
        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL reset_discard: got %0d words want 0", q.size());
        end
        send(1'b1, 2'd3);
        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 1 || q[0] !== 9'h1EA) begin
            n_fail++; $display("FAIL post_reset_word: got %0d words first %h want 1 word 1ea",
                               q.size(), (q.size() > 0) ? q[0] : 9'h0);
        end
    endtask

    task automatic test_lane_b();
        do_reset();
        out_ready = 1'b1;
        send_word(1'b0, 2'd1, 2'd2, 2'd3, 2'd0);
        repeat (6) @(negedge clk);
        n_tests++;
        if (q.size() != 1) begin
            n_fail++; $display("FAIL lane_b_count: got %0d words want 1", q.size());
        end
        n_tests++;
        if (q.size() < 1 || q[0] !== 9'h039) begin
            n_fail++; $display("FAIL lane_b_word: got %h want 039", (q.size() > 0) ? q[0] : 9'h0);
        end
    endtask

    task automatic test_interleave();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 2'd3);
            send(1'b1, 2'd1);
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if (q.size() != 2 || q[0] !== 9'h0FF || q[1] !== 9'h155) begin
            n_fail++;
            $display("FAIL interleave: got %0d words %h %h want 0ff 155", q.size(),
                     (q.size() > 0) ? q[0] : 9'h0, (q.size() > 1) ? q[1] : 9'h0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        ok = 1'b0;
        do_reset();
        send_word(1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
        send_word(1'b1, 2'd3, 2'd2, 2'd1, 2'd0);
        send(1'b1, 2'd1); send(1'b1, 2'd1); send(1'b1, 2'd2);
        @(negedge clk);
        sym_valid = 1'b1; sym_sel = 1'b1; sym_c = 2'd2; sym_b = 2'd1;
        #1;
        n_tests++;
        if (sym_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_12th: sym_ready=%b want 0", sym_ready);
        end
        n_tests++;
        if (q.size() != 0 || out_valid !== 1'b1 || out_data !== 8'hE4) begin
            n_fail++; $display("FAIL bp_hold: words=%0d valid=%b data=%h want 0 1 e4",
                               q.size(), out_valid, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (sym_ready) begin @(posedge clk); ok = 1'b1; end
            else @(negedge clk);
        end
        #1 sym_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_accept_timeout: 12th symbol not accepted");
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if (q.size() != 3 || q[0] !== 9'h1E4 || q[1] !== 9'h11B || q[2] !== 9'h1A5) begin
            n_fail++;
            $display("FAIL bp_order: got %0d words %h %h %h want 1e4 11b 1a5", q.size(),
                     (q.size() > 0) ? q[0] : 9'h0, (q.size() > 1) ? q[1] : 9'h0,
                     (q.size() > 2) ? q[2] : 9'h0);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        send_word(1'b0, 2'd1, 2'd0, 2'd0, 2'd0);
        send_word(1'b0, 2'd2, 2'd0, 2'd0, 2'd0);
        send_word(1'b1, 2'd3, 2'd0, 2'd0, 2'd0);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (q.size() != 3 || q[0] !== 9'h001 || q[1] !== 9'h002 || q[2] !== 9'h103) begin
            n_fail++;
            $display("FAIL arb_round1: got %0d words %h %h %h want 001 002 103", q.size(),
                     (q.size() > 0) ? q[0] : 9'h0, (q.size() > 1) ? q[1] : 9'h0,
                     (q.size() > 2) ? q[2] : 9'h0);
        end
        out_ready = 1'b0;
        q.delete();
        send_word(1'b0, 2'd0, 2'd1, 2'd0, 2'd0);
        send_word(1'b0, 2'd0, 2'd2, 2'd0, 2'd0);
        send_word(1'b1, 2'd0, 2'd3, 2'd0, 2'd0);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (q.size() != 3 || q[0] !== 9'h004 || q[1] !== 9'h10C || q[2] !== 9'h008) begin
            n_fail++;
            $display("FAIL arb_round2: got %0d words %h %h %h want 004 10c 008", q.size(),
                     (q.size() > 0) ? q[0] : 9'h0, (q.size() > 1) ? q[1] : 9'h0,
                     (q.size() > 2) ? q[2] : 9'h0);
        end
    endtask

`ifdef DEMUX_PACK_FLUSH_EN
    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        send(1'b0, 2'd2); send(1'b0, 2'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_tests++;
        if (sym_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: sym_ready=%b want 0", sym_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 1 || q[0] !== 9'h006) begin
            n_fail++; $display("FAIL flush_word: got %0d words %h want 006", q.size(),
                               (q.size() > 0) ? q[0] : 9'h0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lane_b();
        test_interleave();
        test_backpressure();
        test_arbitration();
`ifdef DEMUX_PACK_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
